// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC/prediction logic.
// The branch target buffer is only built when PC_PREDICT_BTB_EN is defined.
package pc_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_ALU    = 2'b10
  } pcsrc_e;

  localparam int CTR_W = 2;

  localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
  localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
  localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
  localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

  // Saturating up/down step of a CTR_W-bit confidence counter.
  function automatic logic [CTR_W-1:0] sat_ctr(input logic [CTR_W-1:0] ctr,
                                               input logic             inc);
    logic [CTR_W-1:0] res;
    if (inc) begin
      res = (ctr == {CTR_W{1'b1}}) ? ctr : ctr + CTR_W'(1);
    end else begin
      res = (ctr == {CTR_W{1'b0}}) ? ctr : ctr - CTR_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on the fetch PC; training from execute is
// registered, so a same-index lookup sees the pre-update contents.
// Instantiated by pc_predict_unit only when PC_PREDICT_BTB_EN is defined.
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int IDXW  = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDXW - 2;
  localparam int TGT_W = XLEN - 2;

  logic [BTB_ENTRIES-1:0]                 valid_q, valid_d;
  logic [BTB_ENTRIES-1:0][CTR_W-1:0]      ctr_q, ctr_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]      tag_q, tag_d;
  logic [BTB_ENTRIES-1:0][TGT_W-1:0]      target_q, target_d;

  logic [IDXW-1:0]  lidx, uidx;
  logic [TAG_W-1:0] ltag, utag;
  logic             lhit, uhit;

  // Byte-offset bits never participate in indexing or targets.
  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign lidx = lookup_pc[IDXW+1:2];
  assign ltag = lookup_pc[XLEN-1:IDXW+2];
  assign uidx = upd_pc[IDXW+1:2];
  assign utag = upd_pc[XLEN-1:IDXW+2];

  // Combinational lookup of the current fetch PC.
  always_comb begin
    lhit        = valid_q[lidx] && (tag_q[lidx] == ltag);
    pred_taken  = lhit && ctr_q[lidx][1];
    pred_target = pred_taken ? {target_q[lidx], 2'b00} : '0;
  end

  // Next-state of the entry array from a resolved execute-stage update.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    uhit     = valid_q[uidx] && (tag_q[uidx] == utag);
    if (upd_en) begin
      if (uhit) begin
        ctr_d[uidx] = sat_ctr(ctr_q[uidx], upd_taken);
        if (upd_taken) begin
          target_d[uidx] = upd_target[XLEN-1:2];
        end
      end else if (upd_taken) begin
        valid_d[uidx]  = 1'b1;
        tag_d[uidx]    = utag;
        target_d[uidx] = upd_target[XLEN-1:2];
        ctr_d[uidx]    = CTR_WT;
      end
    end
  end

  // Valid bits and counters: cleared to empty / weakly-not-taken on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= {BTB_ENTRIES{CTR_WNT}};
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target payload; meaningless until the entry's valid bit is set.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage program counter: PC register, next-PC selection with
// redirect > stall > prediction > sequential priority.
// Define PC_PREDICT_BTB_EN to build the branch target buffer; without it
// the unit is a static not-taken PC and the update ports are ignored.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] UpdatePCE,
  input  logic            UpdateTakenE,
  input  logic [XLEN-1:0] UpdateTargetE,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF
);

  logic [XLEN-1:0] pc_q, pc_d;

  // jalr targets are word-aligned by dropping the two low bits.
  logic unused_alu_low;
  assign unused_alu_low = ^ALUResult[1:0];

  assign PC      = pc_q;
  assign PCPlus4 = pc_q + XLEN'(4);

`ifdef PC_PREDICT_BTB_EN
  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_q),
    .upd_en      (UpdateE),
    .upd_pc      (UpdatePCE),
    .upd_taken   (UpdateTakenE),
    .upd_target  (UpdateTargetE),
    .pred_taken  (PredTakenF),
    .pred_target (PredTargetF)
  );
`else
  logic unused_update;
  assign unused_update = ^{UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE};
  assign PredTakenF    = 1'b0;
  assign PredTargetF   = '0;
`endif

  // Next-PC selection: redirects win over stall, stall over prediction.
  always_comb begin
    pc_d = PCPlus4;
    if (PCSrc == PCSRC_TARGET) begin
      pc_d = PCTarget;
    end else if (PCSrc == PCSRC_ALU) begin
      pc_d = {ALUResult[XLEN-1:2], 2'b00};
    end else if (StallF) begin
      pc_d = pc_q;
    end else if (PredTakenF) begin
      pc_d = PredTargetF;
    end
  end

  // PC register, loaded with the reset vector immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
